xyolo_write: RTL and testbench
==============================

XYOLO_WRITE -- requirements
Module: xyolo_write

Interface
REQ-001 Parameter DATAPATH_W, default 32: width of one datapath result word.
REQ-002 Parameter DATABUS_W, default 256: databus line width; WPL = DATABUS_W/DATAPATH_W words per line (8 at defaults).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 clear  input  1  synchronous clear of configuration registers.
REQ-007 run  input  1  single-cycle start pulse.
REQ-008 done  output  1  high when idle.
REQ-009 valid  input  1  CPU configuration write request.
REQ-010 addr  input  2  configuration register select: 0 EXT_ADDR, 1 LINES, 2 INCR; 3 ignored.
REQ-011 wdata  input  IO_ADDR_W  configuration data.
REQ-012 wstrb  input  1  write qualifier.
REQ-013 flow_in_valid  input  1  datapath word present.
REQ-014 flow_in  input  DATAPATH_W  datapath result word.
REQ-015 flow_in_ready  output  1  block accepts the word this cycle.
REQ-016 databus_valid, databus_addr[IO_ADDR_W], databus_wdata[DATABUS_W], databus_wstrb[DATABUS_W/8]  outputs  write request to external memory.
REQ-017 databus_ready  input  1  request completed; databus_rdata  input  DATABUS_W  ignored.

Function
REQ-018 Config write when valid & wstrb: EXT_ADDR <= wdata (byte address), LINES <= wdata[15:0], INCR <= wdata (byte increment per line); clear or rst zeroes all three.
REQ-019 FSM states IDLE, ACTIVE; reset state IDLE; done = 1 exactly in IDLE.
REQ-020 IDLE & run & LINES != 0 -> ACTIVE next cycle; shadow address, line count and increment latched from config; word counter, line counters, buffer flags zeroed.
REQ-021 IDLE & run & LINES == 0: state stays IDLE, done stays 1, no bus activity.
REQ-022 run while ACTIVE is ignored; config writes during ACTIVE affect only the next run.
REQ-023 Two line buffers (ping-pong), each with a full flag; fill pointer and drain pointer each 1 bit, both 0 at run.
REQ-024 flow_in_ready = ACTIVE & fill buffer not full & words accepted < LINES*WPL.
REQ-025 Accepted word k (0..WPL-1) of a line is written to buffer bits [DATABUS_W-1-k*DATAPATH_W -: DATAPATH_W]; first word occupies the most significant slot.
REQ-026 On acceptance of word WPL-1: fill buffer full flag set, fill pointer toggles, word counter wraps to 0, same cycle.
REQ-027 Drain side: when drain buffer is full and no request outstanding, databus_valid rises the next cycle with wdata = that buffer, wstrb = all ones, addr = shadow address.
REQ-028 databus_valid, addr, wdata, wstrb held stable until the cycle databus_ready is sampled high; valid never drops without ready.
REQ-029 On ready: drain buffer full flag cleared, drain pointer toggles, shadow address += INCR (modulo 2^IO_ADDR_W), lines written += 1; databus_valid low the following cycle unless REQ-027 re-triggers (minimum one idle cycle between requests).
REQ-030 Fill-completion on one buffer and ready on the other in the same cycle are both applied.
REQ-031 Both buffers full -> flow_in_ready = 0; no word lost or overwritten.
REQ-032 ACTIVE -> IDLE on the ready of line LINES-1; done = 1 the following cycle.
REQ-033 flow_in_valid while flow_in_ready = 0 is ignored (datapath responsible for holding).

Reset
REQ-034 rst (any state, including mid-transfer): state IDLE, done = 1, flow_in_ready = 0, databus_valid = 0, databus_addr = 0, databus_wdata = 0, databus_wstrb = 0, config/shadow/counters/flags/buffers = 0.
REQ-035 clear does not abort an active transfer; only config registers are zeroed.

Verification
REQ-036 EXT_ADDR=0x1000, LINES=1, INCR=32, run, feed words 1..8 back-to-back, ready immediate -> one request addr 0x1000, wdata = {1,2,...,8} MS-first, wstrb = 0xFFFFFFFF, done high after ready.
REQ-037 LINES=4, INCR=32, continuous input, ready delayed 5 cycles per request -> addresses 0x1000,0x1020,0x1040,0x1060 in order; flow_in_ready drops while both buffers full; all 32 words arrive intact.
REQ-038 LINES=0, run -> done never drops, databus_valid never asserted.
REQ-039 EXT_ADDR=0xFFFFFFE0, INCR=32, LINES=2 -> second request at address 0x00000000.
REQ-040 rst asserted while databus_valid high awaiting ready -> next cycle all outputs at reset values; new run with LINES=1 completes normally.
REQ-041 run pulsed again mid-transfer and config rewritten during ACTIVE -> current transfer unchanged; new values used on next run.

Source files
------------

// File: rtl/xyolo_write.sv
`default_nettype none
// ============================================================================
//  Module      : xyolo_write
//  Description : Collects datapath result words into two ping-pong line
//                buffers. Each full line is written to external memory as one
//                databus request, at an address that advances by a fixed
//                increment per line.
//  Revision    : 1.0 - initial release
// ============================================================================
module xyolo_write #(
    parameter int DATAPATH_W = 32,
    parameter int DATABUS_W  = 256,
    parameter int IO_ADDR_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   run,
    output logic                   done,
    // CPU configuration port
    input  logic                   valid,
    input  logic [1:0]             addr,
    input  logic [IO_ADDR_W-1:0]   wdata,
    input  logic                   wstrb,
    // datapath input stream
    input  logic                   flow_in_valid,
    input  logic [DATAPATH_W-1:0]  flow_in,
    output logic                   flow_in_ready,
    // external memory write port
    output logic                   databus_valid,
    output logic [IO_ADDR_W-1:0]   databus_addr,
    output logic [DATABUS_W-1:0]   databus_wdata,
    output logic [DATABUS_W/8-1:0] databus_wstrb,
    input  logic                   databus_ready,
    input  logic [DATABUS_W-1:0]   databus_rdata
);

    localparam int c_WPL    = DATABUS_W / DATAPATH_W;
    localparam int c_CNT_W  = (c_WPL > 1) ? $clog2(c_WPL) : 1;
    localparam int c_STRB_W = DATABUS_W / 8;
    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(c_WPL - 1);

    localparam logic [1:0] c_REG_EXT_ADDR = 2'd0;
    localparam logic [1:0] c_REG_LINES    = 2'd1;
    localparam logic [1:0] c_REG_INCR     = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // configuration registers
    logic [IO_ADDR_W-1:0]  r_ext_addr;
    logic [15:0]           r_lines;
    logic [IO_ADDR_W-1:0]  r_incr;

    // per-run shadow copies and progress counters
    logic [IO_ADDR_W-1:0]  r_shadow_addr;
    logic [15:0]           r_line_total;
    logic [IO_ADDR_W-1:0]  r_incr_sh;
    logic [15:0]           r_lines_filled;
    logic [15:0]           r_lines_written;
    logic [c_CNT_W-1:0]    r_word_cnt;

    // ping-pong line buffers
    logic [DATABUS_W-1:0]  r_buf [2];
    logic [1:0]            r_full;
    logic                  r_fill_ptr;
    logic                  r_drain_ptr;

    // registered bus request
    logic                  r_bus_valid;
    logic [IO_ADDR_W-1:0]  r_bus_addr;
    logic [DATABUS_W-1:0]  r_bus_wdata;
    logic [c_STRB_W-1:0]   r_bus_wstrb;

    logic                  w_in_ready;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_fill_done;
    logic                  w_bus_fire;
    logic                  w_last_fire;
    logic                  w_unused_rdata;

    // Read data is never consumed by a write-only engine.
    assign w_unused_rdata = ^databus_rdata;

    // A run with zero lines is treated as a no-op and never leaves IDLE.
    assign w_start     = (r_state == S_IDLE) && run && (r_lines != 16'd0);
    assign w_accept    = flow_in_valid && w_in_ready;
    assign w_fill_done = w_accept && (r_word_cnt == c_LAST_WORD);
    assign w_bus_fire  = r_bus_valid && databus_ready;
    assign w_last_fire = w_bus_fire && (r_lines_written == (r_line_total - 16'd1));

    assign flow_in_ready = w_in_ready;
    assign databus_valid = r_bus_valid;
    assign databus_addr  = r_bus_addr;
    assign databus_wdata = r_bus_wdata;
    assign databus_wstrb = r_bus_wstrb;

    // Configuration register file; clear has priority over a CPU write.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ext_addr <= '0;
            r_lines    <= '0;
            r_incr     <= '0;
        end else if (valid && wstrb) begin
            case (addr)
                c_REG_EXT_ADDR: r_ext_addr <= wdata;
                c_REG_LINES:    r_lines    <= wdata[15:0];
                c_REG_INCR:     r_incr     <= wdata;
                default:        ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state plus done / input-ready decode.
    always_comb begin
        w_state_next = r_state;
        done         = 1'b0;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                done = 1'b1;
                if (w_start) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Word budget is tracked per completed line: the in-line
                // word counter is always below WPL while a line is open.
                w_in_ready = !r_full[r_fill_ptr] && (r_lines_filled < r_line_total);
                if (w_last_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line buffer storage: word k of a line lands in slot k, MS slot first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < c_WPL; k++) begin
                if (r_word_cnt == c_CNT_W'(k)) begin
                    r_buf[r_fill_ptr][DATABUS_W-1-k*DATAPATH_W -: DATAPATH_W] <= flow_in;
                end
            end
        end
    end

    // Fill side: word position, fill pointer and completed-line count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt     <= '0;
            r_fill_ptr     <= 1'b0;
            r_lines_filled <= '0;
        end else if (w_start) begin
            r_word_cnt     <= '0;
            r_fill_ptr     <= 1'b0;
            r_lines_filled <= '0;
        end else if (w_accept) begin
            if (w_fill_done) begin
                r_word_cnt     <= '0;
                r_fill_ptr     <= ~r_fill_ptr;
                r_lines_filled <= r_lines_filled + 16'd1;
            end else begin
                r_word_cnt <= r_word_cnt + c_CNT_W'(1);
            end
        end
    end

    // Drain side: full flags, run shadows and the registered bus request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full          <= '0;
            r_drain_ptr     <= 1'b0;
            r_shadow_addr   <= '0;
            r_line_total    <= '0;
            r_incr_sh       <= '0;
            r_lines_written <= '0;
            r_bus_valid     <= 1'b0;
            r_bus_addr      <= '0;
            r_bus_wdata     <= '0;
            r_bus_wstrb     <= '0;
        end else if (w_start) begin
            r_full          <= '0;
            r_drain_ptr     <= 1'b0;
            r_shadow_addr   <= r_ext_addr;
            r_line_total    <= r_lines;
            r_incr_sh       <= r_incr;
            r_lines_written <= '0;
            r_bus_valid     <= 1'b0;
        end else if (r_state == S_ACTIVE) begin
            // Filling and draining always target different buffers, so a
            // set and a clear in the same cycle never collide.
            if (w_fill_done) begin
                r_full[r_fill_ptr] <= 1'b1;
            end
            if (w_bus_fire) begin
                r_full[r_drain_ptr] <= 1'b0;
                r_drain_ptr         <= ~r_drain_ptr;
                r_shadow_addr       <= r_shadow_addr + r_incr_sh;
                r_lines_written     <= r_lines_written + 16'd1;
                r_bus_valid         <= 1'b0;
            end else if (!r_bus_valid && r_full[r_drain_ptr]) begin
                r_bus_valid <= 1'b1;
                r_bus_addr  <= r_shadow_addr;
                r_bus_wdata <= r_buf[r_drain_ptr];
                r_bus_wstrb <= '1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xyolo_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xyolo_write
//  Description : Directed self-checking bench for xyolo_write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xyolo_write;

    localparam int DW = 32;
    localparam int BW = 256;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            run;
    logic            done;
    logic            valid;
    logic [1:0]      addr;
    logic [AW-1:0]   wdata;
    logic            wstrb;
    logic            flow_in_valid;
    logic [DW-1:0]   flow_in;
    logic            flow_in_ready;
    logic            databus_valid;
    logic [AW-1:0]   databus_addr;
    logic [BW-1:0]   databus_wdata;
    logic [BW/8-1:0] databus_wstrb;
    logic            databus_ready;
    logic [BW-1:0]   databus_rdata;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]   cap_addr [$];
    logic [BW-1:0]   cap_data [$];
    logic [BW/8-1:0] cap_strb [$];
    int              stall_cnt;
    int              hold_err;
    int              idle_err;
    bit              tmo;
    logic            done_after;

    xyolo_write #(
        .DATAPATH_W (DW),
        .DATABUS_W  (BW),
        .IO_ADDR_W  (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .run           (run),
        .done          (done),
        .valid         (valid),
        .addr          (addr),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .flow_in_valid (flow_in_valid),
        .flow_in       (flow_in),
        .flow_in_ready (flow_in_ready),
        .databus_valid (databus_valid),
        .databus_addr  (databus_addr),
        .databus_wdata (databus_wdata),
        .databus_wstrb (databus_wstrb),
        .databus_ready (databus_ready),
        .databus_rdata (databus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        step();
        valid = 1'b0; wstrb = 1'b0; addr = 2'd0; wdata = '0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // Expected line: word k (value first+k) in slot k, most significant first.
    function automatic logic [BW-1:0] exp_line(input int first);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < BW / DW; k++) begin
            v[BW-1-k*DW -: DW] = DW'(first + k);
        end
        return v;
    endfunction

    task automatic feed_words(input int n, input int first);
        int guard;
        for (int i = 0; i < n; i++) begin
            flow_in_valid = 1'b1;
            flow_in       = DW'(first + i);
            guard         = 0;
            while (!flow_in_ready && guard < 400) begin
                stall_cnt++;
                step();
                guard++;
            end
            if (guard >= 400) begin
                tmo = 1'b1;
                break;
            end
            step();
        end
        flow_in_valid = 1'b0;
        flow_in       = '0;
    endtask

    task automatic serve_bus(input int n, input int dly);
        int              guard;
        logic [AW-1:0]   a;
        logic [BW-1:0]   d;
        logic [BW/8-1:0] s;
        for (int r = 0; r < n; r++) begin
            guard = 0;
            while (!databus_valid && guard < 400) begin
                step();
                guard++;
            end
            if (guard >= 400) begin
                tmo = 1'b1;
                return;
            end
            a = databus_addr; d = databus_wdata; s = databus_wstrb;
            cap_addr.push_back(a);
            cap_data.push_back(d);
            cap_strb.push_back(s);
            for (int j = 0; j < dly; j++) begin
                step();
                if (databus_valid !== 1'b1 || databus_addr !== a ||
                    databus_wdata !== d || databus_wstrb !== s) hold_err++;
            end
            databus_ready = 1'b1;
            step();
            databus_ready = 1'b0;
            if (databus_valid !== 1'b0) idle_err++;
            done_after = done;
        end
    endtask

    task automatic do_transfer(input int n_lines, input int dly, input int first);
        cap_addr.delete(); cap_data.delete(); cap_strb.delete();
        stall_cnt = 0; hold_err = 0; idle_err = 0; tmo = 1'b0; done_after = 1'b0;
        fork
            feed_words(n_lines * (BW / DW), first);
            serve_bus(n_lines, dly);
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done: got %b expected 1", done); end
        checks++; if (flow_in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", flow_in_ready); end
        checks++; if (databus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", databus_valid); end
        checks++; if (databus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", databus_addr); end
        checks++; if (databus_wdata !== '0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", databus_wdata); end
        checks++; if (databus_wstrb !== '0) begin errors++; $display("FAIL reset_wstrb: got %h expected 0", databus_wstrb); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_line();
        cfg_write(2'd0, 32'h0000_1000);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'd32);
        pulse_run();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_busy: done got %b expected 0", done); end
        do_transfer(1, 0, 1);
        checks++; if (tmo || cap_addr.size() != 1) begin errors++; $display("FAIL single_count: got %0d requests (timeout %0b) expected 1", cap_addr.size(), tmo); end
        if (cap_addr.size() >= 1) begin
            checks++; if (cap_addr[0] !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %h expected 00001000", cap_addr[0]); end
            checks++; if (cap_data[0] !== 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008) begin
                errors++; $display("FAIL single_data: got %h", cap_data[0]); end
            checks++; if (cap_strb[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_strb: got %h expected ffffffff", cap_strb[0]); end
        end
        checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", done_after); end
        checks++; if (idle_err != 0) begin errors++; $display("FAIL single_idle: valid high after ready %0d times expected 0", idle_err); end
    endtask

    task automatic test_multi_line();
        cfg_write(2'd1, 32'd4);
        pulse_run();
        do_transfer(4, 5, 100);
        checks++; if (tmo || cap_addr.size() != 4) begin errors++; $display("FAIL multi_count: got %0d requests (timeout %0b) expected 4", cap_addr.size(), tmo); end
        for (int i = 0; i < cap_addr.size() && i < 4; i++) begin
            checks++; if (cap_addr[i] !== 32'h1000 + 32'(32 * i)) begin errors++; $display("FAIL multi_addr%0d: got %h expected %h", i, cap_addr[i], 32'h1000 + 32'(32 * i)); end
            checks++; if (cap_data[i] !== exp_line(100 + 8 * i)) begin errors++; $display("FAIL multi_data%0d: got %h", i, cap_data[i]); end
        end
        checks++; if (hold_err != 0) begin errors++; $display("FAIL multi_hold: unstable request %0d cycles expected 0", hold_err); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multi_done: got %b expected 1", done); end
    endtask

    task automatic test_back_to_back();
        pulse_run();
        do_transfer(4, 20, 200);
        checks++; if (tmo || cap_addr.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d requests (timeout %0b) expected 4", cap_addr.size(), tmo); end
        checks++; if (stall_cnt == 0) begin errors++; $display("FAIL b2b_stall: stall cycles got %0d expected nonzero", stall_cnt); end
        for (int i = 0; i < cap_data.size() && i < 4; i++) begin
            checks++; if (cap_data[i] !== exp_line(200 + 8 * i)) begin errors++; $display("FAIL b2b_data%0d: got %h", i, cap_data[i]); end
        end
        checks++; if (hold_err != 0 || idle_err != 0) begin errors++; $display("FAIL b2b_handshake: hold %0d idle %0d expected 0 0", hold_err, idle_err); end
    endtask

    task automatic test_lines_zero();
        int bad;
        cfg_write(2'd1, 32'd0);
        pulse_run();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (done !== 1'b1 || databus_valid !== 1'b0 || flow_in_ready !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL zero_lines: bad cycles got %0d expected 0", bad); end
    endtask

    task automatic test_addr_wrap();
        cfg_write(2'd0, 32'hFFFF_FFE0);
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'd32);
        pulse_run();
        do_transfer(2, 1, 300);
        checks++; if (tmo || cap_addr.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d requests (timeout %0b) expected 2", cap_addr.size(), tmo); end
        if (cap_addr.size() == 2) begin
            checks++; if (cap_addr[0] !== 32'hFFFF_FFE0) begin errors++; $display("FAIL wrap_addr0: got %h expected ffffffe0", cap_addr[0]); end
            checks++; if (cap_addr[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr1: got %h expected 00000000", cap_addr[1]); end
            checks++; if (cap_data[1] !== exp_line(308)) begin errors++; $display("FAIL wrap_data1: got %h", cap_data[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        cfg_write(2'd0, 32'h0000_4000);
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'd32);
        pulse_run();
        stall_cnt = 0; tmo = 1'b0;
        feed_words(8, 400);
        guard = 0;
        while (!databus_valid && guard < 50) begin step(); guard++; end
        checks++; if (databus_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending: valid got %b expected 1", databus_valid); end
        rst = 1'b1;
        step();
        checks++; if (done !== 1'b1 || flow_in_ready !== 1'b0 || databus_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: done %b ready %b valid %b expected 1 0 0", done, flow_in_ready, databus_valid); end
        checks++; if (databus_addr !== 32'h0 || databus_wdata !== '0 || databus_wstrb !== '0) begin
            errors++; $display("FAIL midrst_bus: addr %h wstrb %h expected 0 0", databus_addr, databus_wstrb); end
        rst = 1'b0;
        step();
        cfg_write(2'd0, 32'h0000_2000);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'd32);
        pulse_run();
        do_transfer(1, 2, 500);
        checks++; if (tmo || cap_addr.size() != 1) begin errors++; $display("FAIL midrst_count: got %0d requests (timeout %0b) expected 1", cap_addr.size(), tmo); end
        if (cap_addr.size() == 1) begin
            checks++; if (cap_addr[0] !== 32'h0000_2000 || cap_data[0] !== exp_line(500)) begin
                errors++; $display("FAIL midrst_line: addr %h expected 00002000 data %h", cap_addr[0], cap_data[0]); end
        end
        checks++; if (done_after !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b expected 1", done_after); end
    endtask

    task automatic test_rerun_cfg();
        cfg_write(2'd0, 32'h0000_3000);
        cfg_write(2'd1, 32'd2);
        cfg_write(2'd2, 32'h40);
        pulse_run();
        clear = 1'b1;
        step();
        clear = 1'b0;
        cfg_write(2'd0, 32'h0000_5000);
        cfg_write(2'd1, 32'd1);
        cfg_write(2'd2, 32'h10);
        pulse_run();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rerun_busy: done got %b expected 0", done); end
        do_transfer(2, 3, 600);
        checks++; if (tmo || cap_addr.size() != 2) begin errors++; $display("FAIL rerun_count: got %0d requests (timeout %0b) expected 2", cap_addr.size(), tmo); end
        if (cap_addr.size() == 2) begin
            checks++; if (cap_addr[0] !== 32'h0000_3000) begin errors++; $display("FAIL rerun_addr0: got %h expected 00003000", cap_addr[0]); end
            checks++; if (cap_addr[1] !== 32'h0000_3040) begin errors++; $display("FAIL rerun_addr1: got %h expected 00003040", cap_addr[1]); end
        end
        step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_idle: done got %b expected 1", done); end
        pulse_run();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rerun_next_busy: done got %b expected 0", done); end
        do_transfer(1, 0, 700);
        checks++; if (tmo || cap_addr.size() != 1) begin errors++; $display("FAIL rerun_next_count: got %0d requests (timeout %0b) expected 1", cap_addr.size(), tmo); end
        if (cap_addr.size() == 1) begin
            checks++; if (cap_addr[0] !== 32'h0000_5000 || cap_data[0] !== exp_line(700)) begin
                errors++; $display("FAIL rerun_next_line: addr %h expected 00005000 data %h", cap_addr[0], cap_data[0]); end
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; run = 1'b0;
        valid = 1'b0; addr = 2'd0; wdata = '0; wstrb = 1'b0;
        flow_in_valid = 1'b0; flow_in = '0;
        databus_ready = 1'b0; databus_rdata = '0;
        test_reset();
        test_single_line();
        test_multi_line();
        test_back_to_back();
        test_lines_zero();
        test_addr_wrap();
        test_reset_mid();
        test_rerun_cfg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
